// File: rtl/countdown_pkg.sv
// Shared state encoding and default sizing for the countdown timer.
// Imported by countdown_controller and tick_prescaler.
package countdown_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} cd_state_t;

  localparam int CD_N         = 6;
  localparam int CD_DIV       = 4;
  localparam int CD_BLINK_DIV = 8;

endpackage

// File: rtl/countdown_controller_tick_prescaler.sv
// Free-running divider for the countdown: counts 0..DIV-1 while enabled.
// tick flags the last prescale step; the controller decides whether to use it.
module tick_prescaler
  import countdown_pkg::*;
#(
  parameter int DIV = CD_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] presc_reg;
  logic [W-1:0] presc_next;

  always_comb begin
    presc_next = presc_reg;
    if (clr) begin
      presc_next = '0;
    end else if (en) begin
      presc_next = (presc_reg == LAST) ? '0 : presc_reg + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_next;
    end
  end

  // Ungated so the controller can combine it with its own enable without a loop.
  assign tick = (presc_reg == LAST);

endmodule

// File: rtl/countdown_controller.sv
// Load/start/pause countdown timer with prescaled decrement and done pulse.
// Optional feature macro: BLINK_DONE_EN (blinks the display blank request while in DONE).
module countdown_controller
  import countdown_pkg::*;
#(
  parameter int N         = CD_N,
  parameter int DIV       = CD_DIV,
  parameter int BLINK_DIV = CD_BLINK_DIV
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] load_val,
  input  logic         load,
  input  logic         start,
  input  logic         pause,
  output logic [N-1:0] count,
  output logic         running,
  output logic         done,
  output logic         blank
);

  localparam logic [N-1:0] ONE = N'(1);

  if (DIV < 2 || BLINK_DIV < 2) begin : g_param_chk
    $error("countdown_controller: DIV and BLINK_DIV must be >= 2");
  end

  // Button edge detection: bit 0 load, bit 1 start, bit 2 pause.
  logic [2:0] btn;
  logic [2:0] btn_q_reg;
  logic [2:0] evt;
  assign btn = {pause, start, load};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_edge
      always_ff @(posedge clk) begin
        if (!reset) begin
          btn_q_reg[gi] <= 1'b0;
        end else begin
          btn_q_reg[gi] <= btn[gi];
        end
      end
      assign evt[gi] = btn[gi] & ~btn_q_reg[gi];
    end
  endgenerate

  logic evt_load, evt_start, evt_pause;
  assign evt_load  = evt[0];
  assign evt_start = evt[1];
  assign evt_pause = evt[2];

  cd_state_t    state_reg, state_next;
  logic [N-1:0] count_reg, count_next;
  logic [N-1:0] reload_reg, reload_next;
  logic         done_reg, done_next;
  logic         presc_en, presc_clr, tick;

  tick_prescaler #(.DIV(DIV)) u_presc (
    .clk  (clk),
    .reset(reset),
    .en   (presc_en),
    .clr  (presc_clr),
    .tick (tick)
  );

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    reload_next = reload_reg;
    done_next   = 1'b0;
    presc_en    = 1'b0;
    presc_clr   = 1'b0;
    // Only the highest-priority event of the cycle acts.
    if (evt_load) begin
      count_next  = load_val;
      reload_next = load_val;
      presc_clr   = 1'b1;
      state_next  = IDLE;
    end else if (evt_start) begin
      unique case (state_reg)
        IDLE: begin
          presc_clr = 1'b1;
          if (count_reg == '0) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
        RUN:   presc_en = 1'b1;
        PAUSE: state_next = RUN;
        DONE: begin
          count_next = reload_reg;
          presc_clr  = 1'b1;
          if (reload_reg != '0) state_next = RUN;
          else                  done_next  = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end else if (evt_pause) begin
      if (state_reg == RUN)        state_next = PAUSE;
      else if (state_reg == PAUSE) state_next = RUN;
    end else if (state_reg == RUN) begin
      presc_en = 1'b1;
    end

    if (presc_en && tick) begin
      count_next = count_reg - ONE;
      if (count_reg == ONE) begin
        state_next = DONE;
        done_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      count_reg  <= '1;
      reload_reg <= '1;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      reload_reg <= reload_next;
      done_reg   <= done_next;
    end
  end

  assign count   = count_reg;
  assign running = (state_reg == RUN);
  assign done    = done_reg;

`ifdef BLINK_DONE_EN
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_reg;
  logic          blank_reg;

  always_ff @(posedge clk) begin
    if (!reset || state_next != DONE) begin
      blink_reg <= '0;
      blank_reg <= 1'b0;
    end else if (state_reg == DONE) begin
      if (blink_reg == BLINK_LAST) begin
        blink_reg <= '0;
        blank_reg <= ~blank_reg;
      end else begin
        blink_reg <= blink_reg + BW'(1);
      end
    end
  end

  assign blank = blank_reg;
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_controller.sv
// Randomized + directed bench for countdown_controller against a cycle-level reference model.
// Honours BLINK_DONE_EN the same way the design does.
module tb_countdown_controller;

  localparam int N         = 6;
  localparam int DIV       = 4;
  localparam int BLINK_DIV = 8;
  localparam int MAXV      = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] load_val;
  logic         load, start, pause;
  logic [N-1:0] count;
  logic         running, done, blank;

  countdown_controller #(.N(N), .DIV(DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk     (clk),
    .reset   (reset),
    .load_val(load_val),
    .load    (load),
    .start   (start),
    .pause   (pause),
    .count   (count),
    .running (running),
    .done    (done),
    .blank   (blank)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 counting, 2 paused, 3 finished.
  int m_mode, m_count, m_reload, m_phase, m_done, m_blank, m_blink;
  bit m_pl, m_ps, m_pp;

  task automatic m_advance(inout int nmode);
    if (m_phase == DIV - 1) begin
      m_phase = 0;
      m_count = m_count - 1;
      if (m_count == 0) begin
        nmode  = 3;
        m_done = 1;
      end
    end else begin
      m_phase++;
    end
  endtask

  task automatic model_step();
    bit el, es, ep;
    int nmode;
    if (!reset) begin
      m_mode = 0; m_count = MAXV; m_reload = MAXV; m_phase = 0;
      m_done = 0; m_blank = 0; m_blink = 0;
      m_pl = 0; m_ps = 0; m_pp = 0;
      return;
    end
    el = load & !m_pl; es = start & !m_ps; ep = pause & !m_pp;
    m_pl = load; m_ps = start; m_pp = pause;
    m_done = 0;
    nmode  = m_mode;
    if (el) begin
      m_count = int'(load_val); m_reload = int'(load_val); m_phase = 0; nmode = 0;
    end else if (es) begin
      case (m_mode)
        0: begin
          m_phase = 0;
          if (m_count == 0) begin nmode = 3; m_done = 1; end
          else nmode = 1;
        end
        1: m_advance(nmode);
        2: nmode = 1;
        default: begin
          m_count = m_reload; m_phase = 0;
          if (m_reload != 0) nmode = 1;
          else m_done = 1;
        end
      endcase
    end else if (ep) begin
      if (m_mode == 1) nmode = 2;
      else if (m_mode == 2) nmode = 1;
    end else if (m_mode == 1) begin
      m_advance(nmode);
    end
`ifdef BLINK_DONE_EN
    if (nmode != 3) begin
      m_blink = 0; m_blank = 0;
    end else if (m_mode == 3) begin
      if (m_blink == BLINK_DIV - 1) begin m_blink = 0; m_blank ^= 1; end
      else m_blink++;
    end
`else
    m_blank = 0;
`endif
    m_mode = nmode;
  endtask

  // One clock: drive at negedge, model at posedge, sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check("count",   int'(count),   m_count);
    check("running", int'(running), int'(m_mode == 1));
    check("done",    int'(done),    m_done);
    check("blank",   int'(blank),   m_blank);
  endtask

  task automatic drive(input bit r, input bit l, input bit s, input bit p, input int v);
    @(negedge clk);
    reset = r; load = l; start = s; pause = p; load_val = N'(v);
  endtask

  initial begin
    int first_done, pulses, wait_cyc;
    reset = 1'b0; load = 0; start = 0; pause = 0; load_val = '0;

    // Reset for two cycles.
    drive(0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0); step();
    check("rst_count", int'(count), MAXV);
    check("rst_running", int'(running), 0);

    // Load 5, start, run to zero.
    drive(1, 1, 0, 0, 5); step();
    check("load_count", int'(count), 5);
    drive(1, 1, 1, 0, 5); step();
    check("start_running", int'(running), 1);
    first_done = -1; pulses = 0;
    for (int i = 1; i <= 26; i++) begin
      drive(1, 1, 1, 0, 5); step();
      if (done) begin
        pulses++;
        if (first_done < 0) first_done = i;
      end
    end
    check("done_latency", first_done, 20);
    check("done_pulses", pulses, 1);
    check("end_running", int'(running), 0);
    check("end_count", int'(count), 0);

    // Restart from DONE reloads 5.
    drive(1, 0, 0, 0, 5); step();
    drive(1, 0, 1, 0, 5); step();
    check("restart_count", int'(count), 5);
    check("restart_running", int'(running), 1);

    // Pause at count 3, two cycles into the prescale.
    wait_cyc = 0;
    while (count != 3 && wait_cyc < 40) begin
      drive(1, 0, 1, 0, 5); step(); wait_cyc++;
    end
    check("reach_3_in_time", int'(count), 3);
    drive(1, 0, 1, 0, 5); step();
    drive(1, 0, 1, 0, 5); step();
    drive(1, 0, 1, 1, 5); step();
    for (int i = 0; i < 10; i++) begin drive(1, 0, 1, 1, 5); step(); end
    check("pause_hold", int'(count), 3);
    check("pause_running", int'(running), 0);
    drive(1, 0, 1, 0, 5); step();
    drive(1, 0, 1, 1, 5); step();
    wait_cyc = 0;
    while (count == 3 && wait_cyc < 10) begin
      drive(1, 0, 1, 1, 5); step(); wait_cyc++;
    end
    check("resume_remaining", wait_cyc, 2);

    // Load and start in the same cycle: load wins.
    drive(1, 0, 0, 0, 9); step();
    drive(1, 1, 1, 0, 9); step();
    check("coll_count", int'(count), 9);
    check("coll_running", int'(running), 0);

    // Pause coincident with tick: no decrement.
    drive(1, 1, 0, 0, 9); step();
    drive(1, 1, 1, 0, 9); step();
    for (int i = 0; i < 3; i++) begin drive(1, 1, 1, 0, 9); step(); end
    drive(1, 1, 1, 1, 9); step();
    check("tick_pause_count", int'(count), 9);
    check("tick_pause_running", int'(running), 0);

    // Resume then reset mid-run.
    drive(1, 1, 1, 0, 9); step();
    drive(1, 1, 1, 1, 9); step();
    drive(1, 1, 1, 1, 9); step();
    drive(0, 1, 1, 1, 9); step();
    check("midrst_count", int'(count), MAXV);
    check("midrst_running", int'(running), 0);

    // Randomized levels checked against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      bit r, l, s, p;
      int v;
      r = ($urandom_range(0, 199) != 0);
      l = ($urandom_range(0, 29) == 0) ? ~load  : load;
      s = ($urandom_range(0, 5)  == 0) ? ~start : start;
      p = ($urandom_range(0, 9)  == 0) ? ~pause : pause;
      v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(0, MAXV);
      drive(r, l, s, p, v);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
